alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station feeding the combinational ALU in the out-of-order RISC-V core. It accepts decoded integer and branch instructions from the dispatcher and holds them until both source operands are available. Operands are captured from the two common data bus (CDB) broadcasts, from the ALU and from the load/store buffer. Each cycle at most one ready entry is issued to the ALU through registered operand outputs.

## Interface
Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32)
- RS_IDX_W, 4, log2(RS_SIZE)

Ports (shared widths: OP_W=6, DATA_W=32, TAG_W=5; tag 0 = "no tag / operand ready"):
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state immediately
- rdy  in  1  global enable; low = freeze all state and outputs
- in_clear  in  1  misprediction flush, synchronous
- in_dispatch_en  in  1  dispatch valid this cycle
- in_op  in  OP_W  internal opcode, never NOP when in_dispatch_en=1
- in_value1 / in_value2  in  DATA_W  source values, meaningful when matching tag = 0
- in_tag1 / in_tag2  in  TAG_W  producing ROB tags, 0 if value already valid
- in_imm, in_pc  in  DATA_W  immediate, instruction PC
- in_rob_tag  in  TAG_W  destination ROB tag (non-zero)
- in_alu_cdb_tag, in_lsb_cdb_tag  in  TAG_W  CDB broadcast tags (0 = idle)
- in_alu_cdb_value, in_lsb_cdb_value  in  DATA_W  CDB broadcast values
- out_full  out  1  all entries busy (combinational from entry state)
- out_op  out  OP_W  issued opcode, NOP when nothing issued
- out_value1, out_value2, out_imm, out_pc  out  DATA_W  issued operands
- out_rob_tag  out  TAG_W  issued destination tag

## Operation
- Per entry: busy, op, value1/2, tag1/2, imm, pc, rob_tag.
- Dispatch: when in_dispatch_en=1 and out_full=0, write the lowest-index non-busy entry. If in_dispatch_en=1 while out_full=1, drop the instruction and leave state unchanged; this is a dispatcher error.
- Dispatch forwarding: if in_tagN is non-zero and equals a non-zero CDB tag in the same cycle, store the CDB value and set tagN=0. If both CDBs match, take the ALU CDB.
- Wakeup: every busy entry with tagN equal to a non-zero CDB tag captures that value and sets tagN=0. ALU CDB has priority.
- Select: choose the lowest-index entry that is busy with tag1=0 and tag2=0.
- Issue: at the clock edge, register the selected entry onto the out_* ports and clear its busy bit. With no candidate, out_op=NOP and all other outputs are 0.
- The entry freed by issue is not available to a dispatch in the same cycle.
- Clear: in_clear=1 has priority over dispatch, wakeup and issue. Next cycle all busy=0, out_op=NOP, other outputs 0.
- rdy=0: no dispatch, wakeup or issue; all registers hold. The dispatcher and CDB must also stall.

## Timing
- Reset (rst=0, asynchronous): all busy=0, out_op=NOP, out_value1/2, out_imm, out_pc, out_rob_tag = 0, out_full=0.
- Deasserting rst mid-operation leaves the block empty; no pending entry survives.
- Dispatch with both tags 0, sampled at edge E0: the entry is valid after E0, issues at E1, and the ALU sees it during the E1 cycle. Latency is 2 edges.
- CDB wakeup sampled at E0 (default build): the entry issues at E1.
- At most one issue per cycle; a single CDB can wake multiple entries in one cycle.
- out_full reflects state after the last edge. It does not anticipate a same-cycle issue.

## Configuration
- ALU_RS_WAKEUP_BYPASS_EN defined: select evaluates post-wakeup tags (current CDB matches count as ready). An entry whose last operand arrives on the CDB at E0 issues at E0, with the bypassed value on out_valueN. Wakeup-to-issue is 1 edge.
- Not defined: select uses registered tags only, so wakeup-to-issue is 2 edges. Dispatch latency is unchanged in both builds.

## Structure
- Shared constants live in constant.v: OP_W, DATA_W, TAG_W, NOP, ZERO_TAG_ROB, ZERO_DATA, RS_SIZE.
- Sub-module rs_priority_enc: a parameterised lowest-index-set-bit encoder with a valid flag. Instantiate it twice, once for free-slot search and once for ready-entry select.

## Test plan
- Reset then idle: rst low mid-cycle → out_op=NOP and outputs 0 immediately. out_full=0.
- Ready ADDI dispatch (value1=5, imm=7, tags 0, rob_tag=3) at E0 → at E1 out_op=ADDI, out_value1=5, out_imm=7, out_rob_tag=3.
- ADD dispatched with tag1=4 → never issues until in_alu_cdb_tag=4, value=0x10. It then issues with out_value1=0x10: at E+1 in the default build, at E with the macro.
- Same-cycle forwarding: dispatch with tag2=6 while in_lsb_cdb_tag=6, value=0xAB → issues next edge with out_value2=0xAB.
- Fill 16 independent blocked entries → out_full=1. Extra dispatch is dropped. One wakeup issues that entry and out_full drops the following cycle.
- Full station plus in_clear=1 with simultaneous dispatch → all entries gone, out_op=NOP next cycle, out_full=0. A later CDB broadcast of old tags issues nothing.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, constants and types for the ALU reservation station.
// Contents:
//   OP_W, DATA_W, TAG_W       - opcode, data and ROB tag widths
//   NOP, ZERO_TAG_ROB, ZERO_DATA, RS_SIZE_DEF
//   rs_entry_t                - one station slot (payload only, busy kept separately)
//   issue_t                   - registered issue bundle driven to the ALU
//   operand_t / snoop()       - CDB capture of one source operand
package alu_rs_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;

    localparam logic [OP_W-1:0]   NOP          = '0;
    localparam logic [TAG_W-1:0]  ZERO_TAG_ROB = '0;
    localparam logic [DATA_W-1:0] ZERO_DATA    = '0;
    localparam int unsigned       RS_SIZE_DEF  = 16;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] value1;
        logic [DATA_W-1:0] value2;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  rob_tag;
    } rs_entry_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] value1;
        logic [DATA_W-1:0] value2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  rob_tag;
    } issue_t;

    localparam issue_t IDLE_ISSUE = '{
        op:      NOP,
        value1:  ZERO_DATA,
        value2:  ZERO_DATA,
        imm:     ZERO_DATA,
        pc:      ZERO_DATA,
        rob_tag: ZERO_TAG_ROB
    };

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } operand_t;

    // Capture an operand from the CDBs; ALU CDB wins when both carry the tag.
    function automatic operand_t snoop(input logic [TAG_W-1:0]  tag,
                                       input logic [DATA_W-1:0] value,
                                       input logic [TAG_W-1:0]  alu_tag,
                                       input logic [DATA_W-1:0] alu_value,
                                       input logic [TAG_W-1:0]  lsb_tag,
                                       input logic [DATA_W-1:0] lsb_value);
        operand_t r;
        r.tag   = tag;
        r.value = value;
        if (tag != ZERO_TAG_ROB) begin
            if (tag == alu_tag) begin
                r.tag   = ZERO_TAG_ROB;
                r.value = alu_value;
            end else if (tag == lsb_tag) begin
                r.tag   = ZERO_TAG_ROB;
                r.value = lsb_value;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_priority_enc.sv
// alu_rs_priority_enc: lowest-index set-bit encoder.
// Ports:
//   req   - request vector, N bits
//   idx   - index of the lowest set bit (0 when none set)
//   valid - at least one bit of req is set
module alu_rs_priority_enc #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the combinational ALU.
// Holds dispatched instructions until both source operands are present (captured from the
// ALU and LSB common data buses) and issues at most one ready entry per cycle through
// registered outputs.
//
// Build option: ALU_RS_WAKEUP_BYPASS_EN - when defined, select also treats operands arriving
// on the CDB this cycle as ready, giving one-edge wakeup-to-issue; otherwise two edges.
//
// Ports:
//   clk, rst (async, active-low), rdy (global enable; low freezes everything)
//   in_clear                        - flush all entries and the issue register
//   in_dispatch_en, in_op, in_value1/2, in_tag1/2, in_imm, in_pc, in_rob_tag - dispatch
//   in_alu_cdb_tag/value, in_lsb_cdb_tag/value - CDB broadcasts (tag 0 = idle)
//   out_full                        - every entry busy (from registered state)
//   out_op, out_value1/2, out_imm, out_pc, out_rob_tag - registered issue, NOP when idle
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE  = RS_SIZE_DEF,
    parameter int unsigned RS_IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_clear,
    input  logic              in_dispatch_en,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_value1,
    input  logic [DATA_W-1:0] in_value2,
    input  logic [TAG_W-1:0]  in_tag1,
    input  logic [TAG_W-1:0]  in_tag2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_rob_tag,
    input  logic [TAG_W-1:0]  in_alu_cdb_tag,
    input  logic [DATA_W-1:0] in_alu_cdb_value,
    input  logic [TAG_W-1:0]  in_lsb_cdb_tag,
    input  logic [DATA_W-1:0] in_lsb_cdb_value,
    output logic              out_full,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_value1,
    output logic [DATA_W-1:0] out_value2,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic [TAG_W-1:0]  out_rob_tag
);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    rs_entry_t          entry_q [RS_SIZE];
    rs_entry_t          entry_d [RS_SIZE];
    rs_entry_t          woken   [RS_SIZE];
    operand_t           opd1    [RS_SIZE];
    operand_t           opd2    [RS_SIZE];
    issue_t             out_q, out_d;

    logic [RS_SIZE-1:0]  ready_vec;
    logic [RS_IDX_W-1:0] free_idx, sel_idx;
    logic                free_vld, sel_vld;
    operand_t            disp_opd1, disp_opd2;
    rs_entry_t           disp_entry;

    // Post-wakeup view of every slot.
    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            opd1[i] = snoop(entry_q[i].tag1, entry_q[i].value1, in_alu_cdb_tag,
                            in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value);
            opd2[i] = snoop(entry_q[i].tag2, entry_q[i].value2, in_alu_cdb_tag,
                            in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value);
            woken[i]        = entry_q[i];
            woken[i].tag1   = opd1[i].tag;
            woken[i].value1 = opd1[i].value;
            woken[i].tag2   = opd2[i].tag;
            woken[i].value2 = opd2[i].value;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            ready_vec[i] = busy_q[i] && (woken[i].tag1 == ZERO_TAG_ROB)
                                     && (woken[i].tag2 == ZERO_TAG_ROB);
`else
            ready_vec[i] = busy_q[i] && (entry_q[i].tag1 == ZERO_TAG_ROB)
                                     && (entry_q[i].tag2 == ZERO_TAG_ROB);
`endif
        end
    end

    alu_rs_priority_enc #(
        .N (RS_SIZE),
        .W (RS_IDX_W)
    ) u_free_enc (
        .req   (~busy_q),
        .idx   (free_idx),
        .valid (free_vld)
    );

    alu_rs_priority_enc #(
        .N (RS_SIZE),
        .W (RS_IDX_W)
    ) u_sel_enc (
        .req   (ready_vec),
        .idx   (sel_idx),
        .valid (sel_vld)
    );

    // Dispatch payload with same-cycle CDB forwarding.
    always_comb begin
        disp_opd1 = snoop(in_tag1, in_value1, in_alu_cdb_tag, in_alu_cdb_value,
                          in_lsb_cdb_tag, in_lsb_cdb_value);
        disp_opd2 = snoop(in_tag2, in_value2, in_alu_cdb_tag, in_alu_cdb_value,
                          in_lsb_cdb_tag, in_lsb_cdb_value);
        disp_entry.op      = in_op;
        disp_entry.value1  = disp_opd1.value;
        disp_entry.tag1    = disp_opd1.tag;
        disp_entry.value2  = disp_opd2.value;
        disp_entry.tag2    = disp_opd2.tag;
        disp_entry.imm     = in_imm;
        disp_entry.pc      = in_pc;
        disp_entry.rob_tag = in_rob_tag;
    end

    always_comb begin
        busy_d  = busy_q;
        entry_d = entry_q;
        out_d   = out_q;
        if (rdy) begin
            if (in_clear) begin
                busy_d = '0;
                out_d  = IDLE_ISSUE;
            end else begin
                entry_d = woken;
                out_d   = IDLE_ISSUE;
                if (sel_vld) begin
                    out_d.op      = woken[sel_idx].op;
                    out_d.value1  = woken[sel_idx].value1;
                    out_d.value2  = woken[sel_idx].value2;
                    out_d.imm     = woken[sel_idx].imm;
                    out_d.pc      = woken[sel_idx].pc;
                    out_d.rob_tag = woken[sel_idx].rob_tag;
                    busy_d[sel_idx] = 1'b0;
                end
                // free_idx comes from pre-issue busy, so a slot issued this cycle is
                // never reused before the next edge; a dispatch while full is dropped.
                if (in_dispatch_en && free_vld) begin
                    busy_d[free_idx]  = 1'b1;
                    entry_d[free_idx] = disp_entry;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            out_q  <= IDLE_ISSUE;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            entry_q <= entry_d;
            out_q   <= out_d;
        end
    end

    assign out_full    = &busy_q;
    assign out_op      = out_q.op;
    assign out_value1  = out_q.value1;
    assign out_value2  = out_q.value2;
    assign out_imm     = out_q.imm;
    assign out_pc      = out_q.pc;
    assign out_rob_tag = out_q.rob_tag;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int N = 16;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd2;

    logic              clk, rst, rdy, in_clear, in_dispatch_en;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_value1, in_value2, in_imm, in_pc;
    logic [TAG_W-1:0]  in_tag1, in_tag2, in_rob_tag;
    logic [TAG_W-1:0]  in_alu_cdb_tag, in_lsb_cdb_tag;
    logic [DATA_W-1:0] in_alu_cdb_value, in_lsb_cdb_value;
    logic              out_full;
    logic [OP_W-1:0]   out_op;
    logic [DATA_W-1:0] out_value1, out_value2, out_imm, out_pc;
    logic [TAG_W-1:0]  out_rob_tag;

    alu_rs #(
        .RS_SIZE  (16),
        .RS_IDX_W (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_clear         (in_clear),
        .in_dispatch_en   (in_dispatch_en),
        .in_op            (in_op),
        .in_value1        (in_value1),
        .in_value2        (in_value2),
        .in_tag1          (in_tag1),
        .in_tag2          (in_tag2),
        .in_imm           (in_imm),
        .in_pc            (in_pc),
        .in_rob_tag       (in_rob_tag),
        .in_alu_cdb_tag   (in_alu_cdb_tag),
        .in_alu_cdb_value (in_alu_cdb_value),
        .in_lsb_cdb_tag   (in_lsb_cdb_tag),
        .in_lsb_cdb_value (in_lsb_cdb_value),
        .out_full         (out_full),
        .out_op           (out_op),
        .out_value1       (out_value1),
        .out_value2       (out_value2),
        .out_imm          (out_imm),
        .out_pc           (out_pc),
        .out_rob_tag      (out_rob_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] v1, v2, imm, pc;
        logic [TAG_W-1:0]  rob;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: a set of waiting instructions addressed by slot position.
    bit                m_busy [N];
    logic [OP_W-1:0]   m_op   [N];
    logic [DATA_W-1:0] m_v1   [N];
    logic [DATA_W-1:0] m_v2   [N];
    logic [DATA_W-1:0] m_imm  [N];
    logic [DATA_W-1:0] m_pc   [N];
    logic [TAG_W-1:0]  m_t1   [N];
    logic [TAG_W-1:0]  m_t2   [N];
    logic [TAG_W-1:0]  m_rob  [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operand takes the broadcast value if its producer is on a CDB; ALU bus first.
    task automatic m_snoop(inout logic [TAG_W-1:0] t, inout logic [DATA_W-1:0] v);
        if (t != 0) begin
            if (t == in_alu_cdb_tag) begin
                v = in_alu_cdb_value; t = 0;
            end else if (t == in_lsb_cdb_tag) begin
                v = in_lsb_cdb_value; t = 0;
            end
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        sb.delete();
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        int sel = -1;
        int free = -1;
        logic [TAG_W-1:0]  a, b;
        logic [DATA_W-1:0] va, vb;
        exp_t e;
        if (!rdy) return;
        if (in_clear) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && sel < 0) begin
                a = m_t1[i]; b = m_t2[i]; va = m_v1[i]; vb = m_v2[i];
`ifdef ALU_RS_WAKEUP_BYPASS_EN
                m_snoop(a, va);
                m_snoop(b, vb);
`endif
                if (a == 0 && b == 0) sel = i;
            end
            if (!m_busy[i] && free < 0) free = i;
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
                a = m_t1[i]; va = m_v1[i]; m_snoop(a, va); m_t1[i] = a; m_v1[i] = va;
                b = m_t2[i]; vb = m_v2[i]; m_snoop(b, vb); m_t2[i] = b; m_v2[i] = vb;
            end
        end
        if (sel >= 0) begin
            e.cyc = cyc + 1; e.op = m_op[sel]; e.v1 = m_v1[sel]; e.v2 = m_v2[sel];
            e.imm = m_imm[sel]; e.pc = m_pc[sel]; e.rob = m_rob[sel];
            sb.push_back(e);
            m_busy[sel] = 0;
        end
        if (in_dispatch_en && free >= 0) begin
            a = in_tag1; va = in_value1; m_snoop(a, va);
            b = in_tag2; vb = in_value2; m_snoop(b, vb);
            m_busy[free] = 1; m_op[free] = in_op; m_t1[free] = a; m_v1[free] = va;
            m_t2[free] = b; m_v2[free] = vb; m_imm[free] = in_imm; m_pc[free] = in_pc;
            m_rob[free] = in_rob_tag;
        end
    endtask

    // Monitor: compare every enabled edge against the scoreboard head.
    initial begin : monitor
        logic              r, e;
        exp_t              x;
        logic [OP_W-1:0]   p_op;
        logic [DATA_W-1:0] p_v1, p_v2, p_imm, p_pc;
        logic [TAG_W-1:0]  p_rob;
        p_op = NOP; p_v1 = 0; p_v2 = 0; p_imm = 0; p_pc = 0; p_rob = 0;
        forever begin
            @(posedge clk);
            cyc++;
            r = rst;
            e = rdy;
            #1;
            if (!r) begin
                chk("rst_op", 32'(out_op), 32'(NOP));
                chk("rst_rob", 32'(out_rob_tag), 0);
            end else if (!e) begin
                chk("hold_op", 32'(out_op), 32'(p_op));
                chk("hold_v1", out_value1, p_v1);
                chk("hold_v2", out_value2, p_v2);
                chk("hold_rob", 32'(out_rob_tag), 32'(p_rob));
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                x = sb.pop_front();
                chk("issue_op", 32'(out_op), 32'(x.op));
                chk("issue_v1", out_value1, x.v1);
                chk("issue_v2", out_value2, x.v2);
                chk("issue_imm", out_imm, x.imm);
                chk("issue_pc", out_pc, x.pc);
                chk("issue_rob", 32'(out_rob_tag), 32'(x.rob));
            end else begin
                chk("idle_op", 32'(out_op), 32'(NOP));
                chk("idle_v1", out_value1, 0);
                chk("idle_v2", out_value2, 0);
                chk("idle_imm", out_imm, 0);
                chk("idle_pc", out_pc, 0);
                chk("idle_rob", 32'(out_rob_tag), 0);
            end
            p_op = out_op; p_v1 = out_value1; p_v2 = out_value2;
            p_imm = out_imm; p_pc = out_pc; p_rob = out_rob_tag;
        end
    end

    task automatic set_idle();
        in_clear = 0; in_dispatch_en = 0; in_op = NOP;
        in_value1 = 0; in_value2 = 0; in_tag1 = 0; in_tag2 = 0;
        in_imm = 0; in_pc = 0; in_rob_tag = 0;
        in_alu_cdb_tag = 0; in_alu_cdb_value = 0; in_lsb_cdb_tag = 0; in_lsb_cdb_value = 0;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                        input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v2,
                        input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] imm,
                        input logic [TAG_W-1:0] rob);
        in_dispatch_en = 1; in_op = op; in_value1 = v1; in_tag1 = t1;
        in_value2 = v2; in_tag2 = t2; in_imm = imm; in_pc = 32'h1000 + 32'(rob) * 4;
        in_rob_tag = rob;
    endtask

    // Called at a falling edge with inputs applied; runs one clock.
    task automatic tick();
        chk("full", 32'(out_full), 32'(m_count() == N));
        model_step();
        @(negedge clk);
        set_idle();
    endtask

    initial begin : driver
        rst = 1; rdy = 1;
        set_idle();
        m_reset();
        #1 rst = 0;
        #1;
        chk("por_op", 32'(out_op), 32'(NOP));
        chk("por_full", 32'(out_full), 0);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);

        // Ready ADDI: issues on the second edge.
        disp(OP_ADDI, 5, 0, 0, 0, 7, 3);
        tick(); tick();

        // ADD waiting on tag 4 until the ALU broadcasts it.
        disp(OP_ADD, 0, 4, 9, 0, 0, 8);
        tick(); tick(); tick(); tick();
        in_alu_cdb_tag = 4; in_alu_cdb_value = 32'h10;
        tick(); tick(); tick();

        // Same-cycle forwarding from the LSB CDB.
        disp(OP_ADD, 1, 0, 0, 6, 0, 2);
        in_lsb_cdb_tag = 6; in_lsb_cdb_value = 32'hAB;
        tick(); tick(); tick();

        // Asynchronous reset mid-cycle while an issue is on the outputs.
        disp(OP_ADD, 0, 12, 0, 0, 0, 10);
        tick();
        disp(OP_ADDI, 3, 0, 0, 0, 1, 11);
        tick(); tick();
        #2 rst = 0;
        #1;
        chk("mrst_op", 32'(out_op), 32'(NOP));
        chk("mrst_v1", out_value1, 0);
        chk("mrst_rob", 32'(out_rob_tag), 0);
        chk("mrst_full", 32'(out_full), 0);
        m_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        in_alu_cdb_tag = 12; in_alu_cdb_value = 32'h77;
        tick(); tick(); tick();

        // Fill with blocked entries, overflow, then free one.
        for (int i = 0; i < N; i++) begin
            disp(OP_ADD, 0, 5'(i + 1), 32'(i), 0, 0, 5'(i + 1));
            tick();
        end
        disp(OP_ADD, 0, 0, 0, 0, 0, 20);
        tick();
        in_alu_cdb_tag = 5; in_alu_cdb_value = 32'h55;
        tick(); tick(); tick();

        // Refill, then clear together with a dispatch.
        disp(OP_ADD, 0, 30, 0, 0, 0, 21);
        tick();
        in_clear = 1;
        disp(OP_ADDI, 1, 0, 0, 0, 0, 22);
        tick(); tick();
        for (int t = 1; t <= N; t++) begin
            in_alu_cdb_tag = 5'(t); in_lsb_cdb_tag = 5'(t);
            tick();
        end
        tick();

        // Freeze with noise on the inputs.
        disp(OP_ADDI, 8, 0, 0, 0, 2, 23);
        tick();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 32'(i), 0, 0, 0, 0, 24);
            in_clear = 1;
            tick();
        end
        rdy = 1;
        tick(); tick();

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            rdy = ($urandom_range(9) != 0);
            in_clear = ($urandom_range(49) == 0);
            if ($urandom_range(9) < 6) begin
                disp(6'($urandom_range(63, 1)), $urandom,
                     ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom_range(7, 1)), $urandom,
                     ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom_range(7, 1)), $urandom,
                     5'($urandom_range(31, 1)));
            end
            in_alu_cdb_tag = 5'($urandom_range(7)); in_alu_cdb_value = $urandom;
            in_lsb_cdb_tag = 5'($urandom_range(7)); in_lsb_cdb_value = $urandom;
            tick();
        end
        rdy = 1;

        // Drain everything still waiting.
        for (int k = 0; k < 40; k++) begin
            in_alu_cdb_tag = 5'((k % 7) + 1); in_alu_cdb_value = $urandom;
            in_lsb_cdb_tag = 5'(((k + 3) % 7) + 1); in_lsb_cdb_value = $urandom;
            tick();
        end
        repeat (3) tick();
        chk("drain_sb", 32'(sb.size()), 0);
        chk("drain_full", 32'(out_full), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
